// File: rtl/sva_stim_gen_if.sv
// Command/response bus of the sequence-checker stimulus generator.
// The master issues one directed attempt per command; the slave reports the expected verdict.
interface sva_stim_gen_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_b_dly;
  logic [3:0] cmd_tail;
  logic       busy;
  logic       rsp_valid;
  logic       rsp_exp_pass;

  modport master (
    output cmd_valid, cmd_b_dly, cmd_tail,
    input  cmd_ready, busy, rsp_valid, rsp_exp_pass
  );

  modport slave (
    input  cmd_valid, cmd_b_dly, cmd_tail,
    output cmd_ready, busy, rsp_valid, rsp_exp_pass
  );
endinterface

// File: rtl/sva_stim_gen.sv
// Generates gclk/grst from sys_clk and drives one `a ##[2:4] b` attempt per command,
// with a and b launched on gclk falling edges so they are settled at every gclk rise.
module sva_stim_gen #(
  parameter int GCLK_HALF   = 4,
  parameter int GRST_CYCLES = 3,
  parameter int CNT_W       = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  sva_stim_gen_if.slave    bus,
  output logic             gclk,
  output logic             grst,
  output logic             a,
  output logic             b,
  output logic [CNT_W-1:0] gclk_cnt
);

  localparam int HW = (GCLK_HALF > 1) ? $clog2(GCLK_HALF) : 1;
  localparam int GW = $clog2(GRST_CYCLES + 1);

  typedef enum logic [2:0] {
    GRST, IDLE, LEAD, GAP, WAITB, BPULSE, TAIL, RESP
  } state_t;

  logic [HW-1:0]    r_hcnt;
  logic             r_gclk;
  logic [CNT_W-1:0] r_gcnt;
  logic             w_tog, w_rise, w_fall;

  state_t           r_state, w_state_nxt;
  logic             r_grst, w_grst_nxt;
  logic             r_a, w_a_nxt;
  logic             r_b, w_b_nxt;
  logic [1:0]       r_d, w_d_nxt;
  logic [3:0]       r_t, w_t_nxt;
  logic [3:0]       r_cyc, w_cyc_nxt;
  logic [GW-1:0]    r_gcount, w_gcount_nxt;

  // rise/fall events are the cycles whose clock edge registers the gclk toggle
  assign w_tog  = (r_hcnt == HW'(GCLK_HALF - 1));
  assign w_rise = w_tog & ~r_gclk;
  assign w_fall = w_tog &  r_gclk;

  always_ff @(posedge sys_clk) begin
    // NOTE: synchronous reset -- sys_rst is only looked at on the clock edge, so it
    // lives inside the clocked branch and never appears in the sensitivity list.
    if (sys_rst) begin
      r_hcnt <= '0;
      r_gclk <= 1'b0;
    end else if (w_tog) begin
      r_hcnt <= '0;
      r_gclk <= ~r_gclk;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || r_grst) begin
      r_gcnt <= '0;
    end else if (w_rise) begin
      r_gcnt <= r_gcnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= GRST;
      r_grst   <= 1'b1;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_d      <= '0;
      r_t      <= '0;
      r_cyc    <= '0;
      r_gcount <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grst   <= w_grst_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_d      <= w_d_nxt;
      r_t      <= w_t_nxt;
      r_cyc    <= w_cyc_nxt;
      r_gcount <= w_gcount_nxt;
    end
  end

  always_comb begin
    // NOTE: every next-value defaults to its current value first, so branches that
    // do not touch a signal cannot infer a latch.
    w_state_nxt  = r_state;
    w_grst_nxt   = r_grst;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_d_nxt      = r_d;
    w_t_nxt      = r_t;
    w_cyc_nxt    = r_cyc;
    w_gcount_nxt = r_gcount;

    unique case (r_state)
      GRST: begin
        if (w_rise && (r_gcount != GW'(GRST_CYCLES))) w_gcount_nxt = r_gcount + 1'b1;
        if (w_fall && (r_gcount == GW'(GRST_CYCLES))) begin
          w_grst_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (bus.cmd_valid) begin
          w_d_nxt     = bus.cmd_b_dly;
          w_t_nxt     = bus.cmd_tail;
          w_state_nxt = LEAD;
        end
      end
      LEAD: begin
        // first fall raises a, the following fall ends its single gclk cycle
        if (w_fall) begin
          if (!r_a) begin
            w_a_nxt = 1'b1;
          end else begin
            w_a_nxt     = 1'b0;
            w_state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (w_fall) begin
          if (r_d == 2'd0) begin
            w_b_nxt     = 1'b1;
            w_state_nxt = BPULSE;
          end else begin
            w_cyc_nxt   = {2'b00, r_d};
            w_state_nxt = WAITB;
          end
        end
      end
      WAITB: begin
        if (w_fall) begin
          if (r_cyc == 4'd1) begin
            w_b_nxt     = 1'b1;
            w_state_nxt = BPULSE;
          end else begin
            w_cyc_nxt = r_cyc - 1'b1;
          end
        end
      end
      BPULSE: begin
        if (w_fall) begin
          w_b_nxt = 1'b0;
          if (r_t == 4'd0) begin
            w_state_nxt = RESP;
          end else begin
            w_cyc_nxt   = r_t;
            w_state_nxt = TAIL;
          end
        end
      end
      TAIL: begin
        if (w_fall) begin
          if (r_cyc == 4'd1) w_state_nxt = RESP;
          else               w_cyc_nxt   = r_cyc - 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = GRST;
    endcase
  end

  assign bus.cmd_ready    = (r_state == IDLE);
  assign bus.busy         = (r_state != GRST) && (r_state != IDLE);
  assign bus.rsp_valid    = (r_state == RESP);
  assign bus.rsp_exp_pass = (r_state == RESP) && (r_d != 2'd3);

  assign gclk     = r_gclk;
  assign grst     = r_grst;
  assign a        = r_a;
  assign b        = r_b;
  assign gclk_cnt = r_gcnt;

endmodule

// File: tb/tb_sva_stim_gen.sv
// Directed bench for sva_stim_gen: expected verdicts and b offsets are queued at command
// time and matched against each rsp_valid pulse by a monitor.
module tb_sva_stim_gen;
  localparam int GCLK_HALF   = 4;
  localparam int GRST_CYCLES = 3;
  localparam int CNT_W       = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             gclk, grst, a, b;
  logic [CNT_W-1:0] gclk_cnt;

  sva_stim_gen_if bus ();

  sva_stim_gen #(
    .GCLK_HALF  (GCLK_HALF),
    .GRST_CYCLES(GRST_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus),
    .gclk    (gclk),
    .grst    (grst),
    .a       (a),
    .b       (b),
    .gclk_cnt(gclk_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] d;
    logic       pass;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t drv_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rsp_cnt = 0;
  int   rise_idx = 0;
  int   a_rise = 0, b_rise = 0, a_cnt = 0, b_cnt = 0;
  bit   prev_g = 1'b0;
  bit   ready_due = 1'b0;
  int   n, base, accepts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_rise(output int cycles);
    logic p;
    cycles = 0;
    forever begin
      p = gclk;
      tick();
      cycles++;
      if ((gclk && !p) || cycles >= 64) break;
    end
    check("gclk_rise_in_time", (cycles < 64), 1);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.cmd_ready && k < 500) begin
      tick();
      k++;
    end
    check("ready_wait", bus.cmd_ready, 1);
  endtask

  task automatic run_txn(input logic [1:0] d, input logic [3:0] t);
    int k;
    wait_ready();
    bus.cmd_b_dly = d;
    bus.cmd_tail  = t;
    bus.cmd_valid = 1'b1;
    drv_e.d    = d;
    drv_e.pass = (d != 2'd3);
    sb.push_back(drv_e);
    base = rsp_cnt;
    tick();
    bus.cmd_valid = 1'b0;
    check("ready_low_after_accept", bus.cmd_ready, 0);
    check("busy_after_accept", bus.busy, 1);
    k = 0;
    while (rsp_cnt == base && k < 2000) begin
      tick();
      k++;
    end
    check("rsp_count_txn", rsp_cnt - base, 1);
  endtask

  // Monitor: logs a/b at every gclk rise and scores each response against the queue.
  always @(posedge sys_clk) begin
    #1;
    if (sys_rst) begin
      a_cnt     = 0;
      b_cnt     = 0;
      ready_due = 1'b0;
      prev_g    = gclk;
    end else begin
      if (ready_due) begin
        check("ready_after_resp", bus.cmd_ready, 1);
        ready_due = 1'b0;
      end
      if (gclk && !prev_g) begin
        rise_idx++;
        check("a_b_exclusive", a & b, 0);
        if (a) begin a_cnt++; a_rise = rise_idx; end
        if (b) begin b_cnt++; b_rise = rise_idx; end
      end
      prev_g = gclk;
      if (bus.rsp_valid) begin
        rsp_cnt++;
        check("rsp_was_expected", (sb.size() != 0), 1);
        check("ready_low_in_resp", bus.cmd_ready, 0);
        ready_due = 1'b1;
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("rsp_exp_pass", bus.rsp_exp_pass, mon_e.pass);
          check("b_offset", b_rise - a_rise, 2 + mon_e.d);
          check("a_pulse_count", a_cnt, 1);
          check("b_pulse_count", b_cnt, 1);
        end
        a_cnt = 0;
        b_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_b_dly = '0;
    bus.cmd_tail  = '0;

    // Reset values
    sys_rst = 1'b1;
    repeat (5) tick();
    check("rst_gclk", gclk, 0);
    check("rst_grst", grst, 1);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_exp_pass", bus.rsp_exp_pass, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_gclk_cnt", gclk_cnt, 0);

    // Clock generation and grst sequence, with a command offered during GRST
    sys_rst = 1'b0;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!gclk && n < 100) begin
      tick();
      n++;
    end
    check("first_rise_delay", n, GCLK_HALF);
    check("grst_rise1", grst, 1);
    wait_rise(n);
    check("gclk_period", n, 2 * GCLK_HALF);
    check("grst_rise2", grst, 1);
    wait_rise(n);
    check("grst_rise3", grst, 1);
    check("cnt_held_in_grst", gclk_cnt, 0);
    check("cmd_ignored_in_grst", bus.busy, 0);
    bus.cmd_valid = 1'b0;
    wait_rise(n);
    check("grst_rise4", grst, 0);
    check("cnt_first_rise", gclk_cnt, 1);
    check("no_accept_from_grst", bus.busy, 0);
    check("ready_after_grst", bus.cmd_ready, 1);

    // gclk_cnt wraps modulo 2^CNT_W
    for (int k = 2; k <= 20; k++) begin
      wait_rise(n);
      if (k == 16) check("cnt_wrap_16", gclk_cnt, 0);
    end
    check("cnt_wrap_20", gclk_cnt, 4);

    // Directed attempts covering every b delay
    run_txn(2'd0, 4'd2);
    run_txn(2'd1, 4'd0);
    run_txn(2'd2, 4'd5);
    run_txn(2'd3, 4'd1);

    // cmd_valid held for three back-to-back transactions
    wait_ready();
    bus.cmd_b_dly = 2'd1;
    bus.cmd_tail  = 4'd0;
    bus.cmd_valid = 1'b1;
    base    = rsp_cnt;
    accepts = 0;
    for (int k = 0; k < 4000 && accepts < 3; k++) begin
      if (bus.cmd_ready) begin
        drv_e.d    = 2'd1;
        drv_e.pass = 1'b1;
        sb.push_back(drv_e);
        accepts++;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    n = 0;
    while (rsp_cnt < base + 3 && n < 3000) begin
      tick();
      n++;
    end
    repeat (100) tick();
    check("held_valid_rsp_count", rsp_cnt - base, 3);
    check("held_valid_sb_empty", sb.size(), 0);
    check("held_valid_idle", bus.busy, 0);

    // Abort in WAITB
    wait_ready();
    bus.cmd_b_dly = 2'd3;
    bus.cmd_tail  = 4'd2;
    bus.cmd_valid = 1'b1;
    drv_e.d    = 2'd3;
    drv_e.pass = 1'b0;
    sb.push_back(drv_e);
    tick();
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!a && n < 200) begin
      tick();
      n++;
    end
    check("abort_a_seen", a, 1);
    wait_rise(n);
    wait_rise(n);
    wait_rise(n);
    check("abort_in_waitb_b_low", b, 0);
    check("abort_in_waitb_busy", bus.busy, 1);
    base = rsp_cnt;
    sys_rst = 1'b1;
    tick();
    sb.delete();
    check("abort_a", a, 0);
    check("abort_b", b, 0);
    check("abort_grst", grst, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_ready", bus.cmd_ready, 0);
    sys_rst = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("abort_grst_seq_len", n, 2 * GRST_CYCLES * GCLK_HALF);
    check("abort_no_rsp", rsp_cnt - base, 0);

    // Recovery after abort
    run_txn(2'd0, 4'd0);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
